// File: rtl/morse_letter_ctrl.sv
// Morse letter sequencer: buffers classified dot/dash elements, times key-up gaps,
// and emits letter / word-space strobes. Define MORSE_ASCII_EN to build the ASCII lookup.
module morse_letter_ctrl #(
  parameter int LETTER_GAP = 15,
  parameter int WORD_GAP   = 35,
  parameter int MAX_ELEMS  = 5,
  parameter int GAP_W      = 6
) (
  input  logic                 Clock,
  input  logic                 reset,
  input  logic                 IN,
  input  logic                 dot,
  input  logic                 dash,
  output logic [MAX_ELEMS-1:0] elem_bits,
  output logic [2:0]           elem_cnt,
  output logic                 letter_valid,
  output logic                 letter_err,
  output logic                 word_space,
  output logic [7:0]           ascii
);

  typedef enum logic [1:0] {IDLE, KEYING, GAP, WORD_WAIT} state_t;

  state_t               r_state;
  logic [MAX_ELEMS-1:0] r_buf;
  logic [2:0]           r_cnt;
  logic                 r_err;
  logic [GAP_W-1:0]     r_gap;

  logic                 w_strobe;
  logic                 w_full;
  logic [GAP_W-1:0]     w_gap_inc;
  logic [MAX_ELEMS-1:0] w_buf_app;
  logic [2:0]           w_cnt_app;
  logic                 w_err_app;

  assign w_strobe  = dot | dash;
  assign w_full    = (r_cnt == 3'(MAX_ELEMS));
  assign w_gap_inc = (r_gap == '1) ? r_gap : r_gap + 1'b1;

  // Buffer contents after accepting the current strobe; a double strobe or a full
  // buffer only flags the error and leaves the pattern untouched.
  always_comb begin
    w_buf_app = r_buf;
    w_cnt_app = r_cnt;
    w_err_app = r_err;
    if ((dot & dash) || w_full) begin
      w_err_app = 1'b1;
    end else begin
      w_buf_app = {r_buf[MAX_ELEMS-2:0], dash};
      w_cnt_app = r_cnt + 3'd1;
    end
  end

`ifdef MORSE_ASCII_EN
  logic [7:0] w_ascii;

  function automatic logic [7:0] morse_lookup(input logic [2:0] c, input logic [4:0] b);
    case ({c, b})
      {3'd1, 5'b00000}: morse_lookup = 8'h45; // E
      {3'd1, 5'b00001}: morse_lookup = 8'h54; // T
      {3'd2, 5'b00001}: morse_lookup = 8'h41; // A
      {3'd2, 5'b00000}: morse_lookup = 8'h49; // I
      {3'd2, 5'b00011}: morse_lookup = 8'h4D; // M
      {3'd2, 5'b00010}: morse_lookup = 8'h4E; // N
      {3'd3, 5'b00100}: morse_lookup = 8'h44; // D
      {3'd3, 5'b00110}: morse_lookup = 8'h47; // G
      {3'd3, 5'b00101}: morse_lookup = 8'h4B; // K
      {3'd3, 5'b00111}: morse_lookup = 8'h4F; // O
      {3'd3, 5'b00010}: morse_lookup = 8'h52; // R
      {3'd3, 5'b00000}: morse_lookup = 8'h53; // S
      {3'd3, 5'b00001}: morse_lookup = 8'h55; // U
      {3'd3, 5'b00011}: morse_lookup = 8'h57; // W
      {3'd4, 5'b01000}: morse_lookup = 8'h42; // B
      {3'd4, 5'b01010}: morse_lookup = 8'h43; // C
      {3'd4, 5'b00010}: morse_lookup = 8'h46; // F
      {3'd4, 5'b00000}: morse_lookup = 8'h48; // H
      {3'd4, 5'b00111}: morse_lookup = 8'h4A; // J
      {3'd4, 5'b00100}: morse_lookup = 8'h4C; // L
      {3'd4, 5'b00110}: morse_lookup = 8'h50; // P
      {3'd4, 5'b01101}: morse_lookup = 8'h51; // Q
      {3'd4, 5'b00001}: morse_lookup = 8'h56; // V
      {3'd4, 5'b01001}: morse_lookup = 8'h58; // X
      {3'd4, 5'b01011}: morse_lookup = 8'h59; // Y
      {3'd4, 5'b01100}: morse_lookup = 8'h5A; // Z
      {3'd5, 5'b11111}: morse_lookup = 8'h30;
      {3'd5, 5'b01111}: morse_lookup = 8'h31;
      {3'd5, 5'b00111}: morse_lookup = 8'h32;
      {3'd5, 5'b00011}: morse_lookup = 8'h33;
      {3'd5, 5'b00001}: morse_lookup = 8'h34;
      {3'd5, 5'b00000}: morse_lookup = 8'h35;
      {3'd5, 5'b10000}: morse_lookup = 8'h36;
      {3'd5, 5'b11000}: morse_lookup = 8'h37;
      {3'd5, 5'b11100}: morse_lookup = 8'h38;
      {3'd5, 5'b11110}: morse_lookup = 8'h39;
      default:          morse_lookup = 8'h3F;
    endcase
  endfunction

  assign w_ascii = r_err ? 8'h3F : morse_lookup(r_cnt, 5'(r_buf));
`else
  assign ascii = 8'h00;
`endif

  always_ff @(posedge Clock or negedge reset) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_buf        <= '0;
      r_cnt        <= '0;
      r_err        <= 1'b0;
      r_gap        <= '0;
      elem_bits    <= '0;
      elem_cnt     <= '0;
      letter_valid <= 1'b0;
      letter_err   <= 1'b0;
      word_space   <= 1'b0;
`ifdef MORSE_ASCII_EN
      ascii        <= '0;
`endif
    end else begin
      letter_valid <= 1'b0;
      word_space   <= 1'b0;
      case (r_state)
        IDLE: begin
          r_gap <= '0;
          if (IN) r_state <= KEYING;
        end
        KEYING: begin
          r_gap <= '0;
          if (w_strobe) begin
            r_buf <= w_buf_app;
            r_cnt <= w_cnt_app;
            r_err <= w_err_app;
            if (!IN) r_state <= GAP;
          end
        end
        GAP: begin
          if (w_strobe) begin
            r_buf <= w_buf_app;
            r_cnt <= w_cnt_app;
            r_err <= w_err_app;
            r_gap <= '0;
            if (IN) r_state <= KEYING;
          end else if (IN) begin
            r_gap   <= '0;
            r_state <= KEYING;
          end else begin
            r_gap <= w_gap_inc;
            // Letter is published and the buffer freed on the same edge; the
            // gap counter keeps running towards the word gap.
            if (w_gap_inc == GAP_W'(LETTER_GAP)) begin
              letter_valid <= 1'b1;
              elem_bits    <= r_buf;
              elem_cnt     <= r_cnt;
              letter_err   <= r_err;
`ifdef MORSE_ASCII_EN
              ascii        <= w_ascii;
`endif
              r_buf        <= '0;
              r_cnt        <= '0;
              r_err        <= 1'b0;
              r_state      <= WORD_WAIT;
            end
          end
        end
        WORD_WAIT: begin
          if (IN) begin
            r_gap   <= '0;
            r_state <= KEYING;
          end else if (w_gap_inc == GAP_W'(WORD_GAP)) begin
            word_space <= 1'b1;
            r_gap      <= '0;
            r_state    <= IDLE;
          end else begin
            r_gap <= w_gap_inc;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_morse_letter_ctrl.sv
// Directed bench for morse_letter_ctrl: a table of letters plus hand-written
// sequences for word space, interrupted gaps and mid-letter reset.
module tb_morse_letter_ctrl;

  logic       Clock = 1'b0;
  logic       reset = 1'b0;
  logic       IN    = 1'b0;
  logic       dot   = 1'b0;
  logic       dash  = 1'b0;
  logic [4:0] elem_bits;
  logic [2:0] elem_cnt;
  logic       letter_valid;
  logic       letter_err;
  logic       word_space;
  logic [7:0] ascii;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  morse_letter_ctrl #(
    .LETTER_GAP(15),
    .WORD_GAP  (35),
    .MAX_ELEMS (5),
    .GAP_W     (6)
  ) dut (
    .Clock       (Clock),
    .reset       (reset),
    .IN          (IN),
    .dot         (dot),
    .dash        (dash),
    .elem_bits   (elem_bits),
    .elem_cnt    (elem_cnt),
    .letter_valid(letter_valid),
    .letter_err  (letter_err),
    .word_space  (word_space),
    .ascii       (ascii)
  );

  always #5 Clock = ~Clock;

  // Element codes: {dot,dash}; 2'b10 dot, 2'b01 dash, 2'b11 illegal double strobe.
  typedef struct {
    string       name;
    int unsigned n;
    logic [11:0] els;
    logic [4:0]  bits;
    logic [2:0]  cnt;
    logic        err;
    logic [7:0]  asc;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic i_in, input logic i_dot, input logic i_dash);
    IN = i_in; dot = i_dot; dash = i_dash;
    @(posedge Clock);
    #1;
    dot = 1'b0; dash = 1'b0;
  endtask

  function automatic logic [7:0] exp_ascii(input logic [7:0] a);
`ifdef MORSE_ASCII_EN
    return a;
`else
    return 8'h00 & a;
`endif
  endfunction

  // Runs n key-up cycles; returns how many letter/word strobes were seen.
  task automatic gap(input int unsigned n, output int unsigned lv, output int unsigned ws);
    lv = 0; ws = 0;
    for (int unsigned k = 0; k < n; k++) begin
      step(1'b0, 1'b0, 1'b0);
      if (letter_valid) lv++;
      if (word_space) ws++;
    end
  endtask

  task automatic check_letter(input string nm, input logic [4:0] b, input logic [2:0] c,
                              input logic e, input logic [7:0] a);
    int unsigned lv, ws;
    gap(14, lv, ws);
    chk({nm, " early_strobe"}, lv + ws, 0);
    step(1'b0, 1'b0, 1'b0);
    chk({nm, " letter_valid"}, letter_valid, 1'b1);
    chk({nm, " elem_bits"}, elem_bits, b);
    chk({nm, " elem_cnt"}, elem_cnt, c);
    chk({nm, " letter_err"}, letter_err, e);
    chk({nm, " ascii"}, ascii, exp_ascii(a));
    step(1'b0, 1'b0, 1'b0);
    chk({nm, " one_cycle"}, letter_valid, 1'b0);
    chk({nm, " hold_cnt"}, elem_cnt, c);
  endtask

  initial begin
    int unsigned lv, ws;
    logic [1:0] el;

    vecs[0] = '{"A",   2, 12'b000000000110, 5'b00001, 3'd2, 1'b0, 8'h41};
    vecs[1] = '{"K",   3, 12'b000000011001, 5'b00101, 3'd3, 1'b0, 8'h4B};
    vecs[2] = '{"ovf", 6, 12'b101010101010, 5'b00000, 3'd5, 1'b1, 8'h3F};
    vecs[3] = '{"ill", 2, 12'b000000001011, 5'b00000, 3'd1, 1'b1, 8'h3F};
    vecs[4] = '{"E",   1, 12'b000000000010, 5'b00000, 3'd1, 1'b0, 8'h45};
    vecs[5] = '{"0",   5, 12'b000101010101, 5'b11111, 3'd5, 1'b0, 8'h30};
    vecs[6] = '{"Q",   4, 12'b000001100101, 5'b01101, 3'd4, 1'b0, 8'h51};
    vecs[7] = '{"7",   5, 12'b001010100101, 5'b11000, 3'd5, 1'b0, 8'h37};
    vecs[8] = '{"unk", 4, 12'b000001010101, 5'b01111, 3'd4, 1'b0, 8'h3F};

    // Reset state
    repeat (3) @(posedge Clock);
    #1;
    chk("rst letter_valid", letter_valid, 1'b0);
    chk("rst word_space", word_space, 1'b0);
    chk("rst elem_bits", elem_bits, 5'd0);
    chk("rst elem_cnt", elem_cnt, 3'd0);
    chk("rst letter_err", letter_err, 1'b0);
    chk("rst ascii", ascii, 8'h00);
    reset = 1'b1;

    // Strobes in IDLE (no key-down yet) must not create a letter
    step(1'b0, 1'b1, 1'b0);
    gap(20, lv, ws);
    chk("idle_strobe ignored", lv + ws, 0);

    // Table of letters, each separated by a key-down that cancels the word gap
    for (int unsigned v = 0; v < 9; v++) begin
      for (int unsigned e = 0; e < vecs[v].n; e++) begin
        el = vecs[v].els[2*e +: 2];
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, el[1], el[0]);
      end
      check_letter(vecs[v].name, vecs[v].bits, vecs[v].cnt, vecs[v].err, vecs[v].asc);
    end

    // 'K' followed by a full word gap: word_space 20 cycles after letter_valid
    step(1'b1, 1'b0, 1'b0); step(1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0); step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0); step(1'b0, 1'b0, 1'b1);
    gap(14, lv, ws);
    step(1'b0, 1'b0, 1'b0);
    chk("Kw letter_valid", letter_valid, 1'b1);
    chk("Kw elem_bits", elem_bits, 5'b00101);
    gap(19, lv, ws);
    chk("Kw early_word_space", ws, 0);
    step(1'b0, 1'b0, 1'b0);
    chk("Kw word_space", word_space, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    chk("Kw word_space one_cycle", word_space, 1'b0);
    chk("Kw hold_bits", elem_bits, 5'b00101);
    // Back in IDLE: a stray strobe and long key-up produce nothing
    step(1'b0, 1'b0, 1'b1);
    gap(40, lv, ws);
    chk("Kw idle_quiet", lv + ws, 0);

    // Gap interrupted after 10 cycles: both dots end up in one 'I'
    step(1'b1, 1'b0, 1'b0); step(1'b0, 1'b1, 1'b0);
    gap(10, lv, ws);
    chk("I no_split", lv, 0);
    step(1'b1, 1'b0, 1'b0); step(1'b0, 1'b1, 1'b0);
    check_letter("I", 5'b00000, 3'd2, 1'b0, 8'h49);

    // Reset mid-GAP with two elements buffered
    step(1'b1, 1'b0, 1'b0); step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0); step(1'b0, 1'b0, 1'b1);
    gap(5, lv, ws);
    #2 reset = 1'b0;
    #1;
    chk("midrst elem_cnt", elem_cnt, 3'd0);
    chk("midrst elem_bits", elem_bits, 5'd0);
    chk("midrst letter_valid", letter_valid, 1'b0);
    chk("midrst ascii", ascii, 8'h00);
    @(posedge Clock);
    #1 reset = 1'b1;
    gap(40, lv, ws);
    chk("midrst no_letter", lv + ws, 0);
    chk("midrst cnt_still0", elem_cnt, 3'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
